// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: memory results win, losing ALU results queue in order.
// Optional saturating conflict counter enabled by WB_CONFLICT_STATS_EN.
module wb_port_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dm_valid,
    input  logic [AW-1:0]               dm_rd,
    input  logic [DW-1:0]               ans_dm,
    input  logic                        alu_valid,
    input  logic [AW-1:0]               alu_rd,
    input  logic [DW-1:0]               alu_data,
    output logic                        alu_stall,
    output logic                        rf_we,
    output logic [AW-1:0]               rf_addr,
    output logic [DW-1:0]               rf_wdata,
    output logic [$clog2(DEPTH):0]      pend_cnt,
    output logic [15:0]                 conflict_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t              state;
    logic [AW+DW-1:0]    mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic                alu_acc;
    logic                dm_live;
    logic                pop;
    logic                push;
    logic [CW-1:0]       cnt_nxt;
    logic [AW-1:0]       head_rd;
    logic [DW-1:0]       head_data;

    // Accept/drop decisions and FIFO movement for this cycle; rd==0 requests vanish here.
    always_comb begin
        alu_acc   = alu_valid && !alu_stall && (alu_rd != '0);
        dm_live   = dm_valid && (dm_rd != '0);
        pop       = (state == DRAIN) && !dm_live;
        push      = alu_acc && (dm_live || (state == DRAIN));
        cnt_nxt   = pend_cnt + CW'(push) - CW'(pop);
        {head_rd, head_data} = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pend_cnt  <= '0;
            alu_stall <= 1'b0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
        end else begin
            rf_we <= dm_live || pop || alu_acc;
            if (dm_live) begin
                rf_addr  <= dm_rd;
                rf_wdata <= ans_dm;
            end else if (pop) begin
                rf_addr  <= head_rd;
                rf_wdata <= head_data;
            end else if (alu_acc) begin
                rf_addr  <= alu_rd;
                rf_wdata <= alu_data;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            pend_cnt  <= cnt_nxt;
            alu_stall <= (cnt_nxt == CW'(DEPTH));
            case (state)
                RUN:     if (push && !pop) state <= DRAIN;
                DRAIN:   if (pop && !push && (pend_cnt == CW'(1))) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Pending storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {alu_rd, alu_data};
    end

`ifdef WB_CONFLICT_STATS_EN
    // Counts ALU results that lost the port plus cycles an ALU result sat stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if ((push || (alu_valid && alu_stall)) && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: queue-based reference model, per-cycle expectations
// popped by an independent monitor.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        dm_valid;
    logic [2:0]  dm_rd;
    logic [15:0] ans_dm;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_stall;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic [1:0]  pend_cnt;
    logic [15:0] conflict_cnt;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(3), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .dm_valid(dm_valid), .dm_rd(dm_rd), .ans_dm(ans_dm),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_stall(alu_stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .pend_cnt(pend_cnt), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
        int          pend;
        logic        stall;
        logic [15:0] conf;
    } exp_t;

    exp_t        exp_q[$];
    logic [18:0] pq[$];
    int          m_conf;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endtask

    // Reference model: apply one cycle of the arbitration rules to the pending queue.
    task automatic model_step(input logic r, input logic dv, input logic [2:0] drd, input logic [15:0] dd,
                              input logic av, input logic [2:0] ard, input logic [15:0] ad);
        exp_t e;
        logic stall_now, acc, live;
        e.we = 1'b0;
        if (r) begin
            pq.delete();
            m_conf = 0;
            m_addr = '0;
            m_data = '0;
        end else begin
            stall_now = (pq.size() == DEPTH);
            acc  = av && !stall_now && (ard != 0);
            live = dv && (drd != 0);
            if (live) begin
                e.we = 1'b1; m_addr = drd; m_data = dd;
                if (acc) begin pq.push_back({ard, ad}); m_conf++; end
            end else if (pq.size() > 0) begin
                logic [18:0] h;
                h = pq.pop_front();
                e.we = 1'b1; m_addr = h[18:16]; m_data = h[15:0];
                if (acc) begin pq.push_back({ard, ad}); m_conf++; end
            end else if (acc) begin
                e.we = 1'b1; m_addr = ard; m_data = ad;
            end
            if (av && stall_now) m_conf++;
            if (m_conf > 16'hFFFF) m_conf = 16'hFFFF;
        end
        e.addr  = m_addr;
        e.data  = m_data;
        e.pend  = pq.size();
        e.stall = (pq.size() == DEPTH);
`ifdef WB_CONFLICT_STATS_EN
        e.conf  = 16'(m_conf);
`else
        e.conf  = 16'h0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic dv, input logic [2:0] drd, input logic [15:0] dd,
                       input logic av, input logic [2:0] ard, input logic [15:0] ad);
        reset = r; dm_valid = dv; dm_rd = drd; ans_dm = dd;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        model_step(r, dv, drd, dd, av, ard, ad);
        @(negedge clk);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("rf_addr", 32'(rf_addr), 32'(e.addr));
                chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
                chk("pend_cnt", 32'(pend_cnt), 32'(e.pend));
                chk("alu_stall", 32'(alu_stall), 32'(e.stall));
                chk("conflict_cnt", 32'(conflict_cnt), 32'(e.conf));
            end
        end
    end

    initial begin
        logic       r, dv, av;
        logic [2:0] drd, ard;
        logic [15:0] dd, ad;
        // reset held with both sources active
        cyc(1, 1, 3'd5, 16'hAAAA, 1, 3'd3, 16'h1111);
        cyc(1, 1, 3'd5, 16'hAAAA, 1, 3'd3, 16'h1111);
        // ALU direct write, then rd==0 drop
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd3, 16'h1234);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd0, 16'h1234);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        // same-cycle conflict
        cyc(0, 1, 3'd5, 16'hAAAA, 1, 3'd6, 16'h5555);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        // fill to full, stall, drain in order
        cyc(0, 1, 3'd1, 16'hD001, 1, 3'd2, 16'd1);
        cyc(0, 1, 3'd1, 16'hD002, 1, 3'd2, 16'd2);
        cyc(0, 1, 3'd1, 16'hD003, 1, 3'd2, 16'd3);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd2, 16'd3);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd2, 16'd3);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        // dm with rd==0 does not block ALU
        cyc(0, 1, 3'd0, 16'hBEEF, 1, 3'd4, 16'h0F0F);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        // two pending entries discarded by reset
        cyc(0, 1, 3'd7, 16'h7777, 1, 3'd1, 16'hC001);
        cyc(0, 1, 3'd7, 16'h7778, 1, 3'd2, 16'hC002);
        cyc(1, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        // randomized traffic; upstream holds the ALU result while stalled
        av = 0; ard = 0; ad = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            dv  = ($urandom_range(0, 99) < 45);
            drd = 3'($urandom_range(0, 7));
            dd  = 16'($urandom);
            if (!(av && pq.size() == DEPTH)) begin
                av  = ($urandom_range(0, 99) < 65);
                ard = 3'($urandom_range(0, 7));
                ad  = 16'($urandom);
            end
            cyc(r, dv, drd, dd, av, ard, ad);
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port of the 16-bit MIPS pipeline between two write-back sources: the data-memory load path (ans_dm) and the ALU result path.
- Sits between the write-back stage and the register file.
- Memory results always win the port; ALU results that lose are parked in a small in-order FIFO and drained later.
- Back-pressure to the ALU path is a stall signal.

Parameters:
- DEPTH, 2, pending-FIFO entries for ALU results (power of two, 2..8).
- AW, 3, register address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- dm_valid  in  1  memory result present this cycle (cannot be stalled)
- dm_rd  in  AW  destination register of memory result
- ans_dm  in  DW  memory result data
- alu_valid  in  1  ALU result present
- alu_rd  in  AW  destination register of ALU result
- alu_data  in  DW  ALU result data
- alu_stall  out  1  FIFO full; upstream holds ALU result, block ignores alu_* inputs
- rf_we  out  1  register-file write enable
- rf_addr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- pend_cnt  out  clog2(DEPTH)+1  FIFO occupancy
- conflict_cnt  out  16  conflict statistics (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - rf_we=0, rf_addr=0, rf_wdata=0, alu_stall=0, pend_cnt=0, conflict_cnt=0.
  - FIFO pointers 0; state RUN.
  - Reset mid-operation discards all pending FIFO entries; no write issues in the cycle after reset.
- Accept rules:
  - ALU accepted when alu_valid && !alu_stall.
  - Memory accepted whenever dm_valid.
  - Any accepted request with rd==0 is dropped at accept time: never written, never enqueued, never consumes the port.
- Port selection, one write per cycle, priority order:
  1. Memory result (live dm with rd!=0).
  2. FIFO head.
  3. Accepted ALU result directly.
- An accepted ALU result that does not win the port is pushed to the FIFO tail.
- ALU results never bypass a non-empty FIFO, so ALU writes retire in program order.
- Simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
- Output timing:
  - Outputs are registered. The winner appears on rf_we/rf_addr/rf_wdata on the edge after acceptance (latency 1 cycle).
  - rf_we=0 in any cycle with no winner; rf_addr/rf_wdata hold their last values.
- alu_stall = (pend_cnt == DEPTH), derived from the register.
  - Count DEPTH-1 plus push without pop → full (stall) from the next cycle.
  - No push is possible while full, because ALU inputs are ignored.
- Full with dm_valid: memory is written; ALU stays stalled until a later pop.
- FSM:
  - RUN: FIFO empty. Moves to DRAIN when a push occurs without a pop.
  - DRAIN: FIFO non-empty; pops whenever dm does not take the port. Returns to RUN when the last entry pops with no simultaneous push.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_CONFLICT_STATS_EN.
- Defined: conflict_cnt increments by 1 on every cycle where an accepted ALU result (rd!=0) loses to memory or to the FIFO. It also increments on every cycle alu_valid is held while alu_stall=1. It saturates at 16'hFFFF and clears on reset.
- Undefined: no counter logic; conflict_cnt is tied to 0.

Test Plan:
1. Reset held 2 cycles with alu_valid=1, dm_valid=1 → rf_we=0, alu_stall=0, pend_cnt=0 throughout. First write appears 1 cycle after reset deasserts.
2. alu_valid only, rd=3, data=16'h1234 → next cycle rf_we=1, rf_addr=3, rf_wdata=16'h1234. Same stimulus with rd=0 → rf_we=0.
3. Same-cycle dm (rd=5, 16'hAAAA) and alu (rd=6, 16'h5555) → writes r5=AAAA then r6=5555 on consecutive cycles; pend_cnt goes 1→0; conflict_cnt=1 with macro, 0 without.
4. DEPTH=2; dm_valid and alu_valid both high 3 cycles, alu data 1,2,3 → alu_stall high from cycle 3, data 3 held. After dm stops, writes follow in order 1,2,3 and alu_stall deasserts after the first pop.
5. dm (rd=0) in the same cycle as alu (rd=4, 16'h0F0F) → ALU written directly next cycle; pend_cnt stays 0.
6. FIFO holding 2 entries, reset asserted → pend_cnt=0, rf_we=0. Pending values are never written.
